exe_wb_queue: RTL and testbench

//  Writeback buffer directly downstream of the simple ALU lane; accepts its wbPkt every cycle.

---
 rtl/exe_wb_queue_pkg.sv | 25 ++
 rtl/exe_wb_queue_if.sv | 26 ++
 rtl/exe_wb_queue.sv | 85 ++++++++
 tb/tb_exe_wb_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/exe_wb_queue_pkg.sv
// Shared writeback types and defaults for the ALU-lane writeback queue.
// Holds the wb_pkt_t / exe_flgs_t packet layout and the default buffer depth.
// Imported by the interface, the queue and its bench.
package exe_wb_queue_pkg;

    localparam int EXE_WB_DEPTH = 4;

    typedef struct packed {
        logic mispredict;
        logic exception;
        logic ovf_trap;
        logic br_taken;
    } exe_flgs_t;

    typedef struct packed {
        logic        valid;
        logic [7:0]  seq_no;
        exe_flgs_t   flags;
        logic [4:0]  log_dest;
        logic [6:0]  phy_dest;
        logic [31:0] dest_data;
        logic [5:0]  al_id;
    } wb_pkt_t;

endpackage

// File: rtl/exe_wb_queue_if.sv
// Bundle between the ALU lane / RF write arbiter and the writeback queue.
// slave: the queue (takes wb_in, flush, grant; drives wb_out, ready, occupancy, overflow).
// master: the surrounding pipeline / bench.
interface exe_wb_queue_if
    import exe_wb_queue_pkg::*;
#(
    parameter int CNT_W = $clog2(EXE_WB_DEPTH + 1)
);
    logic             flush;
    wb_pkt_t          wb_in;
    logic             grant;
    wb_pkt_t          wb_out;
    logic             ready;
    logic [CNT_W-1:0] occupancy;
    logic             overflow;

    modport slave (
        input  flush, wb_in, grant,
        output wb_out, ready, occupancy, overflow
    );

    modport master (
        output flush, wb_in, grant,
        input  wb_out, ready, occupancy, overflow
    );
endinterface

// File: rtl/exe_wb_queue.sv
// Writeback buffer: in-order FIFO of ALU results until the RF write port grants.
// Latency: 1 cycle enqueue->head (0 when EXE_WB_FLOWTHRU_EN bypasses an empty queue).
// Backpressure: ready drops when fewer than 2 entries are free; flush empties it.
// Ports: clk, reset (sync, active-high), bus (exe_wb_queue_if.slave).
// Optional macro EXE_WB_FLOWTHRU_EN: empty queue + valid + grant forwards wb_in directly.
module exe_wb_queue
    import exe_wb_queue_pkg::*;
#(
    parameter int DEPTH = EXE_WB_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
)(
    input  logic           clk,
    input  logic           reset,
    exe_wb_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_pkt_t          storage [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             overflow_q;

    logic empty;
    logic full;
    logic bypass;
    logic store_enq;
    logic store_deq;
    logic accept;

    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
`ifdef EXE_WB_FLOWTHRU_EN
        // Nothing older is waiting, so the packet can go straight to the write port.
        bypass = empty & bus.wb_in.valid & bus.grant & ~bus.flush;
`else
        bypass = 1'b0;
`endif
        store_enq = bus.wb_in.valid & ~bus.flush & ~bypass;
        // A grant only pops when a stored entry is actually presented.
        store_deq = ~empty & bus.grant;
        // When full, the packet is only taken if the head leaves the same cycle.
        accept    = store_enq & (~full | store_deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (accept)    tail <= tail + PTR_W'(1);
            if (store_deq) head <= head + PTR_W'(1);
            if (store_enq & full & ~store_deq) overflow_q <= 1'b1;
            case ({accept, store_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload registers need no reset: they are never observed while count is 0.
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && accept) storage[tail] <= bus.wb_in;
    end

    always_comb begin
        bus.wb_out = empty ? '0 : storage[head];
`ifdef EXE_WB_FLOWTHRU_EN
        if (bypass) bus.wb_out = bus.wb_in;
`endif
        // Two free slots: one for the packet now in the ALU stage, one for the next issue.
        bus.ready     = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
        bus.occupancy = count;
        bus.overflow  = overflow_q;
    end

endmodule

// File: tb/tb_exe_wb_queue.sv
// Bench for exe_wb_queue: directed scenarios then randomized traffic, every cycle
// compared against a queue-based reference model of the writeback buffer.
module tb_exe_wb_queue;
    import exe_wb_queue_pkg::*;

    localparam int DEPTH = EXE_WB_DEPTH;
`ifdef EXE_WB_FLOWTHRU_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exe_wb_queue_if bus ();

    exe_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int      errors = 0;
    int      checks = 0;
    wb_pkt_t model_q [$];
    bit      model_ovf = 1'b0;
    wb_pkt_t none = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic wb_pkt_t mk(input logic [7:0] seq, input logic [31:0] data);
        wb_pkt_t p;
        p.valid     = 1'b1;
        p.seq_no    = seq;
        p.flags     = exe_flgs_t'(4'($urandom_range(0, 15)));
        p.log_dest  = 5'($urandom);
        p.phy_dest  = 7'($urandom);
        p.dest_data = data;
        p.al_id     = 6'($urandom);
        return p;
    endfunction

    // One clock: drive inputs at negedge, check outputs, then advance the model
    // to the state the coming posedge will produce.
    task automatic cycle(input bit rst, input bit fl, input wb_pkt_t pkt, input bit gnt, input bit do_chk);
        wb_pkt_t exp_out;
        bit      bypass;
        bit      deq;
        bit      enq;
        @(negedge clk);
        reset     = rst;
        bus.flush = fl;
        bus.wb_in = pkt;
        bus.grant = gnt;
        #1;
        bypass  = FT && model_q.size() == 0 && pkt.valid && gnt && !fl;
        exp_out = bypass ? pkt : (model_q.size() != 0 ? model_q[0] : none);
        if (do_chk) begin
            check("wb_out",    64'(bus.wb_out),    64'(exp_out));
            check("occupancy", 64'(bus.occupancy), 64'(model_q.size()));
            check("ready",     64'(bus.ready),     64'((DEPTH - model_q.size()) >= 2));
            check("overflow",  64'(bus.overflow),  64'(model_ovf));
        end
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (fl) begin
            model_q.delete();
        end else begin
            deq = model_q.size() != 0 && gnt;
            enq = pkt.valid && !bypass;
            if (enq && model_q.size() == DEPTH && !deq) begin
                model_ovf = 1'b1;
            end else begin
                if (deq) void'(model_q.pop_front());
                if (enq) model_q.push_back(pkt);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.flush = 1'b0;
        bus.wb_in = '0;
        bus.grant = 1'b0;

        // Reset held 2 cycles with valid input; queue must come up empty and ready.
        cycle(1, 0, mk(8'd1, 32'd1), 1, 0);
        cycle(1, 0, mk(8'd2, 32'd2), 1, 0);
        cycle(0, 0, none, 0, 1);
        check("rst_occupancy", 64'(bus.occupancy), 64'd0);
        check("rst_valid",     64'(bus.wb_out.valid), 64'd0);
        check("rst_ready",     64'(bus.ready), 64'd1);

        // Streaming with continuous grant.
        cycle(0, 0, mk(8'd5, 32'h55), 1, 1);
        cycle(0, 0, mk(8'd6, 32'h66), 1, 1);
        cycle(0, 0, mk(8'd7, 32'h77), 1, 1);
        cycle(0, 0, none, 1, 1);
        cycle(0, 0, none, 1, 1);

        // Fill to DEPTH with no grant.
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, mk(8'(10 + i), 32'(i)), 0, 1);
        cycle(0, 0, none, 0, 1);
        check("fill_occupancy", 64'(bus.occupancy), 64'(DEPTH));
        check("fill_ready",     64'(bus.ready), 64'd0);
        check("fill_head_seq",  64'(bus.wb_out.seq_no), 64'd10);

        // Full with simultaneous enq/deq, then an enqueue that must overflow.
        cycle(0, 0, mk(8'd9, 32'h99), 1, 1);
        cycle(0, 0, none, 0, 1);
        check("simul_occupancy", 64'(bus.occupancy), 64'(DEPTH));
        check("simul_overflow",  64'(bus.overflow), 64'd0);
        check("simul_head_seq",  64'(bus.wb_out.seq_no), 64'd11);
        cycle(0, 0, mk(8'd20, 32'h20), 0, 1);
        cycle(0, 0, none, 0, 1);
        check("ovf_flag",      64'(bus.overflow), 64'd1);
        check("ovf_occupancy", 64'(bus.occupancy), 64'(DEPTH));
        // Drain: expect 11,12,13,9 (the dropped 20 must never appear).
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, none, 1, 1);

        // Flush with three entries and a same-cycle valid input.
        for (int i = 0; i < 3; i++) cycle(0, 0, mk(8'(40 + i), 32'(i)), 0, 1);
        cycle(0, 1, mk(8'd50, 32'h50), 0, 1);
        cycle(0, 0, none, 0, 1);
        check("flush_occupancy", 64'(bus.occupancy), 64'd0);
        check("flush_valid",     64'(bus.wb_out.valid), 64'd0);
        check("flush_keeps_ovf", 64'(bus.overflow), 64'd1);

        // Reset clears the sticky overflow.
        cycle(1, 0, none, 0, 1);
        cycle(0, 0, none, 0, 1);
        check("rst_clears_ovf", 64'(bus.overflow), 64'd0);

        // Empty queue, granted packet: same cycle with flow-through, next cycle without.
        cycle(0, 0, mk(8'd30, 32'h1234), 1, 1);
        cycle(0, 0, none, 1, 1);
        cycle(0, 0, none, 0, 1);

        // Randomized traffic, issue side honouring ready.
        for (int i = 0; i < 600; i++) begin
            bit      fl;
            bit      gnt;
            bit      vld;
            wb_pkt_t p;
            fl  = ($urandom_range(0, 19) == 0);
            gnt = ($urandom_range(0, 1) == 1);
            vld = ((DEPTH - model_q.size()) >= 2) && ($urandom_range(0, 2) != 0);
            p   = vld ? mk(8'($urandom), $urandom) : none;
            cycle(0, fl, p, gnt, 1);
        end
        check("rand_no_overflow", 64'(bus.overflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
